// File: rtl/filter_bank_loader.sv
// filter_bank_loader: qualifies a bank_select change over several audio
// samples, fades the FIR output gain to mute, copies the new bank's 16
// coefficients from the ROM into the FIR coefficient registers, then fades
// the gain back to unity. The FIR never sees a half-loaded coefficient set
// while the output is audible, and gain changes only on sample strobes, so
// bank changes produce no pops.
module filter_bank_loader #(
    parameter int TAP_WIDTH      = 4,
    parameter int COEF_WIDTH     = 16,
    parameter int STABLE_SAMPLES = 4,
    parameter int GAIN_STEP      = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_sample_strobe,
    input  logic [1:0]             i_bank_select,
    output logic [TAP_WIDTH+1:0]   o_rom_addr,
    input  logic [COEF_WIDTH-1:0]  i_rom_data,
    output logic                   o_coef_we,
    output logic [TAP_WIDTH-1:0]   o_coef_addr,
    output logic [COEF_WIDTH-1:0]  o_coef_data,
    output logic [7:0]             o_gain,
    output logic [1:0]             o_active_bank,
    output logic                   o_busy
);

    localparam int NUM_TAPS = 2 ** TAP_WIDTH;
    localparam int QW       = $clog2(STABLE_SAMPLES + 1);

    localparam logic [7:0]           STEP      = 8'(GAIN_STEP);
    localparam logic [7:0]           UP_SAT    = 8'(255 - GAIN_STEP);
    localparam logic [TAP_WIDTH:0]   TAP_LAST  = (TAP_WIDTH + 1)'(NUM_TAPS);
    localparam logic [QW-1:0]        QUAL_LAST = QW'(STABLE_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUALIFY,
        S_FADE_OUT,
        S_LOAD,
        S_FADE_IN
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_candidate;
    logic [QW-1:0]           r_qual_cnt;
    logic [TAP_WIDTH:0]      r_tap;
    logic [7:0]              r_gain;
    logic                    r_coef_we;
    logic [TAP_WIDTH-1:0]    r_coef_addr;
    logic [COEF_WIDTH-1:0]   r_coef_data;
    logic [1:0]              r_active_bank;
    logic                    r_busy;

    // ROM address comes straight from registers; only meaningful in LOAD.
    assign o_rom_addr    = {r_active_bank, r_tap[TAP_WIDTH-1:0]};
    assign o_coef_we     = r_coef_we;
    assign o_coef_addr   = r_coef_addr;
    assign o_coef_data   = r_coef_data;
    assign o_gain        = r_gain;
    assign o_active_bank = r_active_bank;
    assign o_busy        = r_busy;

    // Bank-change sequencer: qualify, fade out, load, fade in.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // Reset lands in LOAD so bank 0 is always reloaded and faded in.
            r_state       <= S_LOAD;
            r_candidate   <= 2'd0;
            r_qual_cnt    <= '0;
            r_tap         <= '0;
            r_gain        <= 8'd0;
            r_coef_we     <= 1'b0;
            r_coef_addr   <= '0;
            r_coef_data   <= '0;
            r_active_bank <= 2'd0;
            r_busy        <= 1'b1;
        end else begin
            r_coef_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_bank_select != r_active_bank) begin
                        r_state     <= S_QUALIFY;
                        r_candidate <= i_bank_select;
                        r_qual_cnt  <= '0;
                    end
                end
                S_QUALIFY: begin
                    if (i_bank_select == r_active_bank) begin
                        // Selection returned to the loaded bank: glitch.
                        r_state <= S_IDLE;
                    end else if (i_bank_select != r_candidate) begin
                        // A different bank appeared: restart qualification.
                        r_candidate <= i_bank_select;
                        r_qual_cnt  <= '0;
                    end else if (i_sample_strobe) begin
                        r_qual_cnt <= r_qual_cnt + QW'(1);
                        if (r_qual_cnt == QUAL_LAST) begin
                            r_state <= S_FADE_OUT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_FADE_OUT: begin
                    if (i_sample_strobe) begin
                        if (r_gain > STEP) begin
                            r_gain <= r_gain - STEP;
                        end else begin
                            r_gain        <= 8'd0;
                            r_active_bank <= r_candidate;
                            r_tap         <= '0;
                            r_state       <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // ROM data for the tap presented last cycle is valid now.
                    if (r_tap != '0) begin
                        r_coef_we   <= 1'b1;
                        r_coef_addr <= r_tap[TAP_WIDTH-1:0] - TAP_WIDTH'(1);
                        r_coef_data <= i_rom_data;
                    end
                    if (r_tap == TAP_LAST) begin
                        r_state <= S_FADE_IN;
                    end else begin
                        r_tap <= r_tap + (TAP_WIDTH + 1)'(1);
                    end
                end
                S_FADE_IN: begin
                    if (r_gain == 8'hFF) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_sample_strobe) begin
                        r_gain <= (r_gain > UP_SAT) ? 8'hFF : r_gain + STEP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_bank_loader.sv
// Directed, table-driven bench for filter_bank_loader. A registered ROM
// model returns its own address as data, so bank b tap t reads {b,t}.
module tb_filter_bank_loader;

    logic        clk;
    logic        i_reset;
    logic        i_sample_strobe;
    logic [1:0]  i_bank_select;
    logic [5:0]  o_rom_addr;
    logic [15:0] rom_data;
    logic        o_coef_we;
    logic [3:0]  o_coef_addr;
    logic [15:0] o_coef_data;
    logic [7:0]  o_gain;
    logic [1:0]  o_active_bank;
    logic        o_busy;

    filter_bank_loader #(
        .TAP_WIDTH(4), .COEF_WIDTH(16), .STABLE_SAMPLES(4), .GAIN_STEP(32)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_sample_strobe(i_sample_strobe),
        .i_bank_select  (i_bank_select),
        .o_rom_addr     (o_rom_addr),
        .i_rom_data     (rom_data),
        .o_coef_we      (o_coef_we),
        .o_coef_addr    (o_coef_addr),
        .o_coef_data    (o_coef_data),
        .o_gain         (o_gain),
        .o_active_bank  (o_active_bank),
        .o_busy         (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with one clock of read latency; word value = address.
    always @(posedge clk) rom_data <= 16'(o_rom_addr);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: capture coefficient writes, check write bursts are 16 long,
    // writes only while busy, and gain only moves on strobe edges.
    logic [19:0] wq[$];
    int          we_run = 0;
    logic [7:0]  prev_gain = 8'd0;
    logic        mon_strobe;
    bit          mon_skip = 1'b1;

    always @(posedge clk) begin
        mon_strobe = i_sample_strobe;
        #2;
        if (!mon_skip && o_gain !== prev_gain) check("gain_on_strobe", 32'(mon_strobe), 32'd1);
        prev_gain = o_gain;
        if (o_coef_we === 1'b1) begin
            check("we_while_busy", 32'(o_busy), 32'd1);
            wq.push_back({o_coef_addr, o_coef_data});
            we_run++;
        end else if (we_run != 0) begin
            check("we_run_len", 32'(we_run), 32'd16);
            we_run = 0;
        end
    end

    task automatic check_writes(input logic [1:0] bank);
        int n;
        logic [19:0] w;
        n = wq.size();
        check("wr_count", 32'(n), 32'd16);
        for (int i = 0; i < n && i < 16; i++) begin
            w = wq.pop_front();
            check("wr_addr", 32'(w[19:16]), 32'(i));
            check("wr_data", 32'(w[15:0]), 32'({bank, 4'(i)}));
        end
        wq.delete();
    endtask

    // chk: 0 none, 1 expect 16 writes of bank, 2 expect no writes.
    typedef struct {
        logic [1:0] bs;
        bit         strobe;
        int         idle;
        logic [7:0] gain;
        bit         busy;
        logic [1:0] bank;
        int         chk;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [1:0] bs, input bit s, input int idle,
                                input logic [7:0] g, input bit b, input logic [1:0] bk,
                                input int chk);
        vec_t v;
        v.bs = bs; v.strobe = s; v.idle = idle; v.gain = g;
        v.busy = b; v.bank = bk; v.chk = chk;
        tbl.push_back(v);
    endfunction

    // Select a new bank, qualify it over 4 strobes, fade fully out.
    function automatic void add_fade_out(input logic [1:0] bs, input logic [1:0] old_bank);
        add(bs, 1'b0, 2, 8'd255, 1'b0, old_bank, 2);
        for (int i = 0; i < 3; i++) add(bs, 1'b1, 2, 8'd255, 1'b0, old_bank, 0);
        add(bs, 1'b1, 2, 8'd255, 1'b1, old_bank, 0);
        for (int i = 1; i <= 7; i++) add(bs, 1'b1, 2, 8'(255 - 32 * i), 1'b1, old_bank, 0);
        add(bs, 1'b1, 2, 8'd0, 1'b1, bs, 0);
    endfunction

    // Let LOAD finish, check the 16 writes, then fade in.
    function automatic void add_load_fade_in(input logic [1:0] bs, input logic [1:0] bank,
                                             input bit last);
        add(bs, 1'b0, 25, 8'd0, 1'b1, bank, 1);
        for (int i = 1; i <= 7; i++) add(bs, 1'b1, 2, 8'(32 * i), 1'b1, bank, 0);
        if (last) add(bs, 1'b1, 2, 8'd255, 1'b0, bank, 0);
    endfunction

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            i_bank_select   = tbl[i].bs;
            i_sample_strobe = tbl[i].strobe;
            @(negedge clk);
            i_sample_strobe = 1'b0;
            repeat (tbl[i].idle) @(negedge clk);
            $display("vec %0d: bs=%0d strobe=%0d gain=%0d busy=%0d bank=%0d", i,
                     tbl[i].bs, tbl[i].strobe, o_gain, o_busy, o_active_bank);
            check("gain", 32'(o_gain), 32'(tbl[i].gain));
            check("busy", 32'(o_busy), 32'(tbl[i].busy));
            check("active_bank", 32'(o_active_bank), 32'(tbl[i].bank));
            if (tbl[i].chk == 1) check_writes(tbl[i].bank);
            if (tbl[i].chk == 2) check("wr_none", 32'(wq.size()), 32'd0);
        end
    endtask

    int mark_a, mark_f;

    initial begin
        i_reset         = 1'b1;
        i_sample_strobe = 1'b0;
        i_bank_select   = 2'd0;

        // Reset release: bank 0 load and partial fade-in (last step by hand).
        add_load_fade_in(2'd0, 2'd0, 1'b0);
        mark_a = tbl.size();
        // Switch to bank 2.
        add_fade_out(2'd2, 2'd0);
        add_load_fade_in(2'd2, 2'd2, 1'b1);
        // Glitch to bank 1 for two strobes, then back to the loaded bank.
        add(2'd1, 1'b0, 2, 8'd255, 1'b0, 2'd2, 0);
        add(2'd1, 1'b1, 2, 8'd255, 1'b0, 2'd2, 0);
        add(2'd1, 1'b1, 2, 8'd255, 1'b0, 2'd2, 0);
        add(2'd2, 1'b0, 2, 8'd255, 1'b0, 2'd2, 2);
        for (int i = 0; i < 4; i++) add(2'd2, 1'b1, 2, 8'd255, 1'b0, 2'd2, 0);
        // Re-candidate: bank 1 for two strobes, then bank 3 held.
        add(2'd1, 1'b0, 2, 8'd255, 1'b0, 2'd2, 0);
        add(2'd1, 1'b1, 2, 8'd255, 1'b0, 2'd2, 0);
        add(2'd1, 1'b1, 2, 8'd255, 1'b0, 2'd2, 0);
        add_fade_out(2'd3, 2'd2);
        add_load_fade_in(2'd3, 2'd3, 1'b1);
        // Bank 2, with selection moving to 1 while bank 2 loads.
        add_fade_out(2'd2, 2'd3);
        add_load_fade_in(2'd1, 2'd2, 1'b1);
        add_fade_out(2'd1, 2'd2);
        add_load_fade_in(2'd1, 2'd1, 1'b1);
        // Start a fade-out back to bank 0, stop at gain 95.
        add(2'd0, 1'b0, 2, 8'd255, 1'b0, 2'd1, 2);
        for (int i = 0; i < 3; i++) add(2'd0, 1'b1, 2, 8'd255, 1'b0, 2'd1, 0);
        add(2'd0, 1'b1, 2, 8'd255, 1'b1, 2'd1, 0);
        for (int i = 1; i <= 5; i++) add(2'd0, 1'b1, 2, 8'(255 - 32 * i), 1'b1, 2'd1, 0);
        mark_f = tbl.size();
        // After the mid-fade reset: bank 0 reload and fade-in.
        add_load_fade_in(2'd0, 2'd0, 1'b1);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_gain", 32'(o_gain), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd1);
        check("rst_bank", 32'(o_active_bank), 32'd0);
        check("rst_we", 32'(o_coef_we), 32'd0);
        check("rst_rom_addr", 32'(o_rom_addr), 32'd0);
        check("rst_coef_addr", 32'(o_coef_addr), 32'd0);
        check("rst_coef_data", 32'(o_coef_data), 32'd0);
        i_reset  = 1'b0;
        mon_skip = 1'b0;

        run_table(0, mark_a);

        // Last fade-in step: gain hits 255 with busy still high,
        // busy drops one clock later.
        @(negedge clk);
        i_sample_strobe = 1'b1;
        @(negedge clk);
        i_sample_strobe = 1'b0;
        $display("hand: gain=%0d busy=%0d at first 255 cycle", o_gain, o_busy);
        check("gain_255", 32'(o_gain), 32'd255);
        check("busy_hold", 32'(o_busy), 32'd1);
        @(negedge clk);
        $display("hand: busy=%0d one clock later", o_busy);
        check("busy_fall", 32'(o_busy), 32'd0);

        run_table(mark_a, mark_f);

        // Asynchronous reset mid-fade-out, between clock edges.
        mon_skip = 1'b1;
        i_reset  = 1'b1;
        #1;
        $display("hand: async reset gain=%0d bank=%0d we=%0d", o_gain, o_active_bank, o_coef_we);
        check("arst_gain", 32'(o_gain), 32'd0);
        check("arst_bank", 32'(o_active_bank), 32'd0);
        check("arst_we", 32'(o_coef_we), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd1);
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;

        run_table(mark_f, tbl.size());

        repeat (4) @(negedge clk);
        check("wr_tail_none", 32'(wq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
